alu_control_muldiv: RTL and testbench

//  Next-generation ALU control for the MIPS EX stage. Decodes ALUOp/funct into the
//  3-bit ALUControl exactly as the current decoder does, and adds MULTU/DIVU/MFHI/

---
 rtl/alu_control_muldiv.sv | 154 +++++++++++++++
 tb/tb_alu_control_muldiv.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_muldiv.sv
// EX-stage ALU control decode plus HI/LO registers and an iterative unsigned multiply/divide unit.
// Decode is combinational; MULTU/DIVU occupy WIDTH cycles, HI/LO-dependent R-types stall meanwhile.
module alu_control_muldiv #(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [2:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [2:0]       ALUControl,
  output logic [1:0]       res_sel,
  output logic             md_busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 is_rtype;
  logic                 hilo_op;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   step_next;

  assign is_rtype = (ALUOp == 3'b010);
  assign hilo_op  = (funct == F_MFHI) || (funct == F_MFLO) || (funct == F_MTHI) ||
                    (funct == F_MTLO) || (funct == F_MULTU) || (funct == F_DIVU);

  always_comb begin
    ALUControl = 3'b000;
    res_sel    = 2'b00;
    case (ALUOp)
      3'b000: ALUControl = 3'b010;
      3'b001: ALUControl = 3'b110;
      3'b011: ALUControl = 3'b111;
      3'b100: ALUControl = 3'b110;
      3'b110: ALUControl = 3'b001;
      3'b111: ALUControl = 3'b011;
      3'b010: begin
        case (funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          6'b100110: ALUControl = 3'b011;
          6'b100111: ALUControl = 3'b100;
          default:   ALUControl = 3'b000;
        endcase
        if (funct == F_MFHI) res_sel = 2'b01;
        if (funct == F_MFLO) res_sel = 2'b10;
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Shift-add: upper half accumulates, lower half holds the remaining multiplier bits.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  assign step_next = (state_q == S_DIV) ? div_next : mul_next;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (valid && is_rtype) begin
          if (funct == F_MULTU) begin
            state_d = S_MUL;
            cnt_d   = 6'(WIDTH);
            acc_d   = {{WIDTH{1'b0}}, srcb};
            opb_d   = srca;
          end else if ((funct == F_DIVU) && DIV_EN) begin
            state_d = S_DIV;
            cnt_d   = 6'(WIDTH);
            acc_d   = {{WIDTH{1'b0}}, srca};
            opb_d   = srcb;
          end else if (funct == F_MTHI) begin
            hi_d = srca;
          end else if (funct == F_MTLO) begin
            lo_d = srca;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d = step_next;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          hi_d    = step_next[2*WIDTH-1:WIDTH];
          lo_d    = step_next[WIDTH-1:0];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md_busy = (state_q != S_IDLE);
  assign stall   = !reset && valid && md_busy && is_rtype && hilo_op;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Directed bench: stimulus pushes time-tagged expectations, a negedge monitor pops and compares.
module tb_alu_control_muldiv;

  logic        clk = 1'b0;
  logic        reset, valid, valid0;
  logic [2:0]  ALUOp;
  logic [5:0]  funct;
  logic [31:0] srca, srcb;
  logic [2:0]  ALUControl, ALUControl0;
  logic [1:0]  res_sel, res_sel0;
  logic        md_busy, md_busy0, stall, stall0;
  logic [31:0] hi, lo, hi0, lo0;

  always #5 clk = ~clk;

  alu_control_muldiv #(.WIDTH(32), .DIV_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ALUOp(ALUOp), .funct(funct),
    .srca(srca), .srcb(srcb), .ALUControl(ALUControl), .res_sel(res_sel),
    .md_busy(md_busy), .stall(stall), .hi(hi), .lo(lo));

  alu_control_muldiv #(.WIDTH(32), .DIV_EN(1'b0)) dut_nodiv (
    .clk(clk), .reset(reset), .valid(valid0), .ALUOp(ALUOp), .funct(funct),
    .srca(srca), .srcb(srcb), .ALUControl(ALUControl0), .res_sel(res_sel0),
    .md_busy(md_busy0), .stall(stall0), .hi(hi0), .lo(lo0));

  localparam int F_CTL = 0, F_SEL = 1, F_BUSY = 2, F_STALL = 3, F_HI = 4, F_LO = 5;
  localparam int F_CTL0 = 6, F_SEL0 = 7, F_BUSY0 = 8, F_STALL0 = 9, F_HI0 = 10, F_LO0 = 11;

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(int fld);
    case (fld)
      F_CTL:    return {29'd0, ALUControl};
      F_SEL:    return {30'd0, res_sel};
      F_BUSY:   return {31'd0, md_busy};
      F_STALL:  return {31'd0, stall};
      F_HI:     return hi;
      F_LO:     return lo;
      F_CTL0:   return {29'd0, ALUControl0};
      F_SEL0:   return {30'd0, res_sel0};
      F_BUSY0:  return {31'd0, md_busy0};
      F_STALL0: return {31'd0, stall0};
      F_HI0:    return hi0;
      F_LO0:    return lo0;
      default:  return 32'hxxxxxxxx;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = observe(sb[i].fld);
        n_vec++;
        if (act !== sb[i].exp) begin
          n_err++;
          $display("FAIL %s @cyc %0d: got %h, expected %h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int dly, input int fld, input logic [31:0] e, input string nm);
    exp_t x;
    x.cyc  = cyc + dly;
    x.fld  = fld;
    x.exp  = e;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    valid = v;
    ALUOp = op;
    funct = f;
    srca  = a;
    srcb  = b;
  endtask

  // Issue a MULTU/DIVU, scramble operands afterwards, and check busy window and result.
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    drive(1'b1, 3'b010, f, a, b);
    expect_at(0, F_BUSY, 32'd0, {nm, "_busy_pre"});
    for (int k = 1; k <= 32; k++) expect_at(k, F_BUSY, 32'd1, {nm, "_busy"});
    expect_at(33, F_BUSY, 32'd0, {nm, "_busy_done"});
    expect_at(33, F_HI, ehi, {nm, "_hi"});
    expect_at(33, F_LO, elo, {nm, "_lo"});
    step(1);
    drive(1'b0, 3'b000, 6'd0, 32'h12345678, 32'h0);
    step(33);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [5:0] f;
    logic [2:0] ctl;
    logic [1:0] sel;
  } dec_t;

  dec_t dec_tab[17] = '{
    '{3'b010, 6'b101010, 3'b111, 2'b00},
    '{3'b000, 6'b011001, 3'b010, 2'b00},
    '{3'b001, 6'b011001, 3'b110, 2'b00},
    '{3'b011, 6'b011011, 3'b111, 2'b00},
    '{3'b100, 6'b011001, 3'b110, 2'b00},
    '{3'b101, 6'b100000, 3'b000, 2'b00},
    '{3'b110, 6'b011011, 3'b001, 2'b00},
    '{3'b111, 6'b011001, 3'b011, 2'b00},
    '{3'b010, 6'b100000, 3'b010, 2'b00},
    '{3'b010, 6'b100010, 3'b110, 2'b00},
    '{3'b010, 6'b100100, 3'b000, 2'b00},
    '{3'b010, 6'b100101, 3'b001, 2'b00},
    '{3'b010, 6'b100110, 3'b011, 2'b00},
    '{3'b010, 6'b100111, 3'b100, 2'b00},
    '{3'b010, 6'b011000, 3'b000, 2'b00},
    '{3'b010, 6'b010000, 3'b000, 2'b01},
    '{3'b010, 6'b010010, 3'b000, 2'b10}
  };

  initial begin
    reset  = 1'b1;
    valid0 = 1'b0;
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0);
    step(1);
    if (md_busy !== 1'b0) begin
      n_err++;
      $display("FAIL direct_rst_busy: got %b", md_busy);
    end
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL direct_rst_stall: got %b", stall);
    end
    if (hi !== 32'd0) begin
      n_err++;
      $display("FAIL direct_rst_hi: got %h", hi);
    end
    if (lo !== 32'd0) begin
      n_err++;
      $display("FAIL direct_rst_lo: got %h", lo);
    end
    expect_at(0, F_BUSY, 32'd0, "rst_busy");
    expect_at(0, F_STALL, 32'd0, "rst_stall");
    expect_at(0, F_HI, 32'd0, "rst_hi");
    expect_at(0, F_LO, 32'd0, "rst_lo");
    expect_at(0, F_BUSY0, 32'd0, "rst_busy0");
    step(1);
    reset = 1'b0;

    foreach (dec_tab[i]) begin
      drive(1'b1, dec_tab[i].op, dec_tab[i].f, 32'd9, 32'd4);
      expect_at(0, F_CTL, {29'd0, dec_tab[i].ctl}, "dec_ctl");
      expect_at(0, F_SEL, {30'd0, dec_tab[i].sel}, "dec_sel");
      expect_at(0, F_STALL, 32'd0, "dec_stall");
      step(1);
    end
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0);
    expect_at(0, F_BUSY, 32'd0, "dec_no_start");

    run_md(6'b011001, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, "mul_ffx2");
    run_md(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, "mul_max");
    run_md(6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, "div_100_7");
    run_md(6'b011011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, "div_by0");
    run_md(6'b011011, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, "div_big");

    // MULTU, independent ADD, then MFLO waiting on the product.
    drive(1'b1, 3'b010, 6'b011001, 32'd3, 32'd5);
    step(1);
    drive(1'b1, 3'b010, 6'b100000, 32'd1, 32'd2);
    expect_at(0, F_STALL, 32'd0, "add_no_stall");
    expect_at(0, F_CTL, 32'd2, "add_ctl");
    step(1);
    drive(1'b1, 3'b010, 6'b010010, 32'd0, 32'd0);
    for (int k = 0; k <= 30; k++) expect_at(k, F_STALL, 32'd1, "mflo_stall");
    expect_at(31, F_STALL, 32'd0, "mflo_release");
    expect_at(31, F_SEL, 32'd2, "mflo_sel");
    expect_at(31, F_LO, 32'd15, "mflo_lo");
    expect_at(31, F_HI, 32'd0, "mflo_hi");
    step(32);
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0);
    step(1);

    // DIVU presented while a MULTU is running waits, then runs.
    drive(1'b1, 3'b010, 6'b011001, 32'd6, 32'd7);
    step(1);
    drive(1'b1, 3'b010, 6'b011011, 32'd100, 32'd7);
    for (int k = 0; k <= 31; k++) expect_at(k, F_STALL, 32'd1, "divu_held_stall");
    expect_at(32, F_LO, 32'd42, "held_mul_lo");
    expect_at(33, F_BUSY, 32'd1, "held_div_running");
    step(33);
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0);
    expect_at(40, F_BUSY, 32'd0, "held_div_done");
    expect_at(40, F_LO, 32'd14, "held_div_lo");
    expect_at(40, F_HI, 32'd2, "held_div_hi");
    step(41);

    // Reset in the middle of a divide.
    drive(1'b1, 3'b010, 6'b011011, 32'd1000, 32'd3);
    step(1);
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0);
    step(9);
    reset = 1'b1;
    expect_at(1, F_BUSY, 32'd0, "midrst_busy");
    expect_at(1, F_HI, 32'd0, "midrst_hi");
    expect_at(1, F_LO, 32'd0, "midrst_lo");
    expect_at(1, F_STALL, 32'd0, "midrst_stall");
    step(1);
    reset = 1'b0;
    drive(1'b1, 3'b010, 6'b010001, 32'hABCD, 32'd0);
    expect_at(1, F_HI, 32'hABCD, "mthi_hi");
    expect_at(1, F_LO, 32'd0, "mthi_lo");
    step(1);
    drive(1'b1, 3'b010, 6'b010011, 32'h1234, 32'd0);
    expect_at(1, F_LO, 32'h1234, "mtlo_lo");
    expect_at(1, F_HI, 32'hABCD, "mtlo_hi");
    step(1);
    if (lo !== 32'h1234) begin
      n_err++;
      $display("FAIL direct_mtlo_lo: got %h", lo);
    end
    if (hi !== 32'hABCD) begin
      n_err++;
      $display("FAIL direct_mtlo_hi: got %h", hi);
    end
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0);

    // Build without divider: DIVU is a no-op.
    valid0 = 1'b1;
    drive(1'b0, 3'b010, 6'b010011, 32'h55, 32'd0);
    expect_at(1, F_LO0, 32'h55, "nodiv_mtlo");
    step(1);
    drive(1'b0, 3'b010, 6'b011011, 32'd100, 32'd7);
    expect_at(0, F_CTL0, 32'd0, "nodiv_ctl");
    expect_at(0, F_SEL0, 32'd0, "nodiv_sel");
    expect_at(0, F_STALL0, 32'd0, "nodiv_stall");
    expect_at(1, F_BUSY0, 32'd0, "nodiv_busy1");
    expect_at(2, F_BUSY0, 32'd0, "nodiv_busy2");
    expect_at(33, F_BUSY0, 32'd0, "nodiv_busy33");
    expect_at(33, F_LO0, 32'h55, "nodiv_lo");
    expect_at(33, F_HI0, 32'd0, "nodiv_hi");
    step(1);
    valid0 = 1'b0;
    step(35);
    if (md_busy0 !== 1'b0) begin
      n_err++;
      $display("FAIL direct_nodiv_busy: got %b", md_busy0);
    end
    if (lo0 !== 32'h55) begin
      n_err++;
      $display("FAIL direct_nodiv_lo: got %h", lo0);
    end
    if (hi0 !== 32'd0) begin
      n_err++;
      $display("FAIL direct_nodiv_hi: got %h", hi0);
    end

    foreach (sb[i]) begin
      n_err++;
      $display("FAIL %s: expectation for cyc %0d never checked, expected %h", sb[i].name, sb[i].cyc, sb[i].exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
